// File: rtl/score_engine.sv
// Clocked saturating score engine for the spell-tracing game: scores trace samples,
// applies double/bonus/streak power-ups and tracks a persistent high score.
module score_engine #(
  parameter int W          = 32,
  parameter int HIT_PTS    = 300,
  parameter int MISS_PTS   = 100,
  parameter int BONUS_PTS  = 150,
  parameter int DOUBLE_LEN = 8,
  parameter int STREAK_LEN = 4,
  parameter int STREAK_PTS = 50
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         sample_valid,
  input  logic         in_trace,
  input  logic         power_bonus,
  input  logic         power_double,
  input  logic         clear,
  output logic [W-1:0] score,
  output logic [W-1:0] high_score,
  output logic [7:0]   streak,
  output logic         double_active,
  output logic         bonus_pending,
  output logic         saturated
);

  localparam int CW = (DOUBLE_LEN < 1) ? 1 : $clog2(DOUBLE_LEN + 1);

  localparam logic [W+1:0] MAX_X    = {2'b00, {W{1'b1}}};
  localparam logic [W+1:0] ZERO_X   = {(W+2){1'b0}};
  localparam logic [W+1:0] HIT_X    = (W+2)'(HIT_PTS);
  localparam logic [W+1:0] BONUS_X  = (W+2)'(BONUS_PTS);
  localparam logic [W+1:0] STREAK_X = (W+2)'(STREAK_PTS);
  localparam logic [W-1:0] MISS_W   = W'(MISS_PTS);
  localparam logic [CW-1:0] DLEN    = CW'(DOUBLE_LEN);
  localparam logic [CW-1:0] DLEN_M1 = CW'(DOUBLE_LEN - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [8:0]    STR_LEN9 = 9'(STREAK_LEN);

  logic [W-1:0]  score_q, score_d;
  logic [W-1:0]  high_q, high_d;
  logic [7:0]    streak_q, streak_d;
  logic [CW-1:0] dbl_cnt_q, dbl_cnt_d;
  logic          bonus_q, bonus_d;
  logic          sat_q, sat_d;
  logic          dact_q, dact_d;

  logic          dbl_s;
  logic          bon_s;
  logic          award_s;
  logic [8:0]    streak_p1_s;
  logic [W+1:0]  add_s;
  logic [W+1:0]  sum_s;

  // Next-state computation for score, streak, power-up state and high score
  always_comb begin
    score_d     = score_q;
    streak_d    = streak_q;
    dbl_cnt_d   = dbl_cnt_q;
    bonus_d     = bonus_q;
    sat_d       = sat_q;
    dbl_s       = (dbl_cnt_q != CNT_ZERO) || power_double;
    bon_s       = bonus_q || power_bonus;
    streak_p1_s = {1'b0, streak_q} + 9'd1;
    award_s     = ((streak_p1_s % STR_LEN9) == 9'd0);
    add_s       = (dbl_s ? (HIT_X + HIT_X) : HIT_X)
                + (bon_s ? BONUS_X : ZERO_X)
                + (award_s ? STREAK_X : ZERO_X);
    sum_s       = {2'b00, score_q} + add_s;

    if (clear) begin
      // Clear beats any sample and swallows coincident power pulses
      score_d   = {W{1'b0}};
      streak_d  = 8'd0;
      dbl_cnt_d = CNT_ZERO;
      bonus_d   = 1'b0;
      sat_d     = 1'b0;
    end else begin
      if (sample_valid && in_trace) begin
        if (sum_s > MAX_X) begin
          score_d = {W{1'b1}};
          sat_d   = 1'b1;
        end else begin
          score_d = sum_s[W-1:0];
        end
        streak_d = (streak_q == 8'd255) ? 8'd255 : streak_p1_s[7:0];
        bonus_d  = 1'b0;
      end else if (sample_valid) begin
        if (score_q <= MISS_W) begin
          score_d = {W{1'b0}};
        end else begin
          score_d = score_q - MISS_W;
        end
        streak_d = 8'd0;
        bonus_d  = bon_s;
      end else begin
        bonus_d = bon_s;
      end

      // A reload wins over the decrement; a coincident sample has already used one slot
      if (power_double) begin
        dbl_cnt_d = sample_valid ? DLEN_M1 : DLEN;
      end else if (sample_valid && (dbl_cnt_q != CNT_ZERO)) begin
        dbl_cnt_d = dbl_cnt_q - CNT_ONE;
      end else begin
        dbl_cnt_d = dbl_cnt_q;
      end
    end

    high_d = (score_d > high_q) ? score_d : high_q;
    dact_d = (dbl_cnt_d != CNT_ZERO);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      score_q   <= {W{1'b0}};
      high_q    <= {W{1'b0}};
      streak_q  <= 8'd0;
      dbl_cnt_q <= CNT_ZERO;
      bonus_q   <= 1'b0;
      sat_q     <= 1'b0;
      dact_q    <= 1'b0;
    end else begin
      score_q   <= score_d;
      high_q    <= high_d;
      streak_q  <= streak_d;
      dbl_cnt_q <= dbl_cnt_d;
      bonus_q   <= bonus_d;
      sat_q     <= sat_d;
      dact_q    <= dact_d;
    end
  end

  assign score         = score_q;
  assign high_score    = high_q;
  assign streak        = streak_q;
  assign double_active = dact_q;
  assign bonus_pending = bonus_q;
  assign saturated     = sat_q;

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: a 32-bit instance and a 12-bit instance share stimulus.
module tb_score_engine;

  logic clock;
  logic resetn;
  logic sample_valid, in_trace, power_bonus, power_double, clear;

  logic [31:0] score, high_score;
  logic [7:0]  streak;
  logic        double_active, bonus_pending, saturated;

  logic [11:0] score12, high12;
  logic [7:0]  streak12;
  logic        dact12, bon12, sat12;

  int total = 0;
  int bad   = 0;

  score_engine #(.W(32)) dut (
    .clock(clock), .resetn(resetn), .sample_valid(sample_valid), .in_trace(in_trace),
    .power_bonus(power_bonus), .power_double(power_double), .clear(clear),
    .score(score), .high_score(high_score), .streak(streak),
    .double_active(double_active), .bonus_pending(bonus_pending), .saturated(saturated)
  );

  score_engine #(.W(12)) dut12 (
    .clock(clock), .resetn(resetn), .sample_valid(sample_valid), .in_trace(in_trace),
    .power_bonus(power_bonus), .power_double(power_double), .clear(clear),
    .score(score12), .high_score(high12), .streak(streak12),
    .double_active(dact12), .bonus_pending(bon12), .saturated(sat12)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns #1 after the edge with inputs idle
  task automatic tick(input logic v, input logic t, input logic pb, input logic pd, input logic cl);
    sample_valid = v; in_trace = t; power_bonus = pb; power_double = pd; clear = cl;
    @(posedge clock);
    #1;
    sample_valid = 1'b0; in_trace = 1'b0; power_bonus = 1'b0; power_double = 1'b0; clear = 1'b0;
  endtask

  task automatic hit();  tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic miss(); tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    sample_valid = 1'b0; in_trace = 1'b0; power_bonus = 1'b0; power_double = 1'b0; clear = 1'b0;
    do_reset();
    chk("rst_score", score, 64'd0);
    chk("rst_high", high_score, 64'd0);
    chk("rst_streak", streak, 64'd0);
    chk("rst_dbl", double_active, 64'd0);
    chk("rst_bon", bonus_pending, 64'd0);
    chk("rst_sat", saturated, 64'd0);

    hit(); chk("h1", score, 64'd300);
    hit(); chk("h2", score, 64'd600);
    hit(); chk("h3", score, 64'd900);
    chk("h3_streak", streak, 64'd3);
    chk("h3_high", high_score, 64'd900);

    // Bonus coincident with a hit, then misses down to the floor
    do_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("cb_score", score, 64'd450);
    chk("cb_bon", bonus_pending, 64'd0);
    miss(); miss(); miss();
    chk("m_150", score, 64'd150);
    miss(); chk("m_50", score, 64'd50);
    miss(); chk("m_floor", score, 64'd0);
    chk("m_streak", streak, 64'd0);
    chk("m_high", high_score, 64'd450);

    // Standalone bonus arm
    do_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("arm_bon", bonus_pending, 64'd1);
    chk("arm_score", score, 64'd0);
    hit();
    chk("bon_hit", score, 64'd450);
    chk("bon_used", bonus_pending, 64'd0);
    hit(); chk("bon_next", score, 64'd750);

    // Double window of 8 samples
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("dbl_first", score, 64'd600);
    chk("dbl_act", double_active, 64'd1);
    hit(); hit();
    chk("dbl_s3", score, 64'd1800);
    miss(); miss(); miss(); miss();
    chk("dbl_s7_act", double_active, 64'd1);
    miss();
    chk("dbl_s8_act", double_active, 64'd0);
    chk("dbl_s8", score, 64'd1300);
    hit();
    chk("dbl_s9", score, 64'd1600);
    chk("dbl_high", high_score, 64'd1800);

    // Reload at sample 5 extends the window
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    miss(); miss(); miss();
    chk("rl_s4", score, 64'd300);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rl_s5", score, 64'd900);
    for (int i = 0; i < 6; i++) miss();
    chk("rl_s11_act", double_active, 64'd1);
    miss();
    chk("rl_s12_act", double_active, 64'd0);
    hit();
    chk("rl_s13", score, 64'd500);

    // Streak awards
    do_reset();
    hit(); hit(); hit();
    hit(); chk("stk_award1", score, 64'd1250);
    miss(); chk("stk_miss", score, 64'd1150);
    chk("stk_reset", streak, 64'd0);
    hit(); hit(); hit();
    chk("stk_noaward", score, 64'd2050);
    hit(); chk("stk_award2", score, 64'd2400);
    chk("stk_cnt", streak, 64'd4);

    // Walk both instances to 3900, then clip the 12-bit one
    do_reset();
    for (int i = 0; i < 4; i++) hit();
    miss();
    for (int i = 0; i < 4; i++) hit();
    miss();
    for (int i = 0; i < 3; i++) hit();
    miss();
    for (int i = 0; i < 3; i++) hit();
    miss();
    chk("sat_pre12", score12, 64'd3900);
    chk("sat_pre32", score, 64'd3900);
    hit();
    chk("sat_score12", score12, 64'd4095);
    chk("sat_flag12", sat12, 64'd1);
    chk("sat_high12", high12, 64'd4095);
    chk("sat_score32", score, 64'd4200);
    chk("sat_flag32", saturated, 64'd0);

    // Clear wins over a hit with both power pulses
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_score12", score12, 64'd0);
    chk("clr_sat12", sat12, 64'd0);
    chk("clr_high12", high12, 64'd4095);
    chk("clr_dbl12", dact12, 64'd0);
    chk("clr_bon12", bon12, 64'd0);
    chk("clr_streak12", streak12, 64'd0);
    hit();
    chk("post_clr12", score12, 64'd300);
    chk("post_clr_high12", high12, 64'd4095);

    // Asynchronous reset between edges
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_score12", score12, 64'd0);
    chk("ar_high12", high12, 64'd0);
    chk("ar_dbl12", dact12, 64'd0);
    chk("ar_bon12", bon12, 64'd0);
    chk("ar_high32", high_score, 64'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    hit();
    chk("ar_nopower", score12, 64'd300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
